// File: rtl/wb_pkg.sv
// Shared types for the Wishbone host master.
//   wb_state_e : FSM states of the host master
//   wb_rsp_t   : response record {dat, err} at the default data width
//   ADR_W_DEF / DAT_W_DEF : default bus widths
package wb_pkg;
  localparam int ADR_W_DEF = 32;
  localparam int DAT_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic [DAT_W_DEF-1:0] dat;
    logic                 err;
  } wb_rsp_t;
endpackage

// File: rtl/wb_host_master_if.sv
// Wishbone classic bus between the host master and a slave.
//   master modport: drives cyc/stb/we/sel/adr/dat_o, samples dat_i/ack
//   slave  modport: the mirror image
interface wb_host_master_if import wb_pkg::*; #(
  parameter int ADR_W = ADR_W_DEF,
  parameter int DAT_W = DAT_W_DEF,
  localparam int SEL_W = DAT_W / 8
) ();
  logic             wbm_cyc_o;
  logic             wbm_stb_o;
  logic             wbm_we_o;
  logic [SEL_W-1:0] wbm_sel_o;
  logic [ADR_W-1:0] wbm_adr_o;
  logic [DAT_W-1:0] wbm_dat_o;
  logic [DAT_W-1:0] wbm_dat_i;
  logic             wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/wb_timeout_cnt.sv
// Ack-wait counter. Clears on clr_i, counts up on en_i, and flags exp_o
// when the count has reached TIMEOUT-1 (the last allowed wait cycle).
//   clk_i, rst_n_i : clock, async active-low reset
//   clr_i, en_i    : clear (wins over enable), count enable
//   exp_o          : expiry flag
module wb_timeout_cnt #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 16
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clr_i,
  input  logic en_i,
  output logic exp_o
);
  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign exp_o = (cnt_q == LAST);
endmodule

// File: rtl/wb_host_master.sv
// Wishbone classic-cycle initiator. Takes one command on a valid/ready
// stream, runs a single Wishbone access, and returns read data or an ack
// timeout error on a valid/ready response stream.
//   wb_clk_i, wb_rst_n_i : clock, async active-low reset
//   cmd_*                : command stream (we/adr/dat/sel)
//   rsp_*                : response stream (dat, err)
//   wbm                  : Wishbone master bus
module wb_host_master import wb_pkg::*; #(
  parameter int ADR_W   = ADR_W_DEF,
  parameter int DAT_W   = DAT_W_DEF,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 16,
  localparam int SEL_W  = DAT_W / 8
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_we_i,
  input  logic [ADR_W-1:0] cmd_adr_i,
  input  logic [DAT_W-1:0] cmd_dat_i,
  input  logic [SEL_W-1:0] cmd_sel_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [DAT_W-1:0] rsp_dat_o,
  output logic             rsp_err_o,
  wb_host_master_if.master wbm
);
  // Response record at this instance's data width.
  typedef struct packed {
    logic [DAT_W-1:0] dat;
    logic             err;
  } rsp_t;

  wb_state_e        state_q, state_d;
  logic             we_q, we_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [DAT_W-1:0] dat_q, dat_d;
  rsp_t             rsp_q, rsp_d;
  logic             to_clr, to_en, to_exp;

  wb_timeout_cnt #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_to (
    .clk_i  (wb_clk_i),
    .rst_n_i(wb_rst_n_i),
    .clr_i  (to_clr),
    .en_i   (to_en),
    .exp_o  (to_exp)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    rsp_d   = rsp_q;
    to_clr  = 1'b0;
    to_en   = 1'b0;
    case (state_q)
      IDLE: begin
        if (cmd_valid_i) begin
          we_d    = cmd_we_i;
          sel_d   = cmd_sel_i;
          adr_d   = cmd_adr_i;
          dat_d   = cmd_dat_i;
          to_clr  = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        // Ack is tested first so an ack on the expiry edge still completes.
        if (wbm.wbm_ack_i) begin
          rsp_d.dat = we_q ? '0 : wbm.wbm_dat_i;
          rsp_d.err = 1'b0;
          we_d      = 1'b0;
          sel_d     = '0;
          state_d   = RESP;
        end else if (to_exp) begin
          rsp_d.dat = '0;
          rsp_d.err = 1'b1;
          we_d      = 1'b0;
          sel_d     = '0;
          state_d   = RESP;
        end else begin
          to_en = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      rsp_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      rsp_q   <= rsp_d;
    end
  end

  // cyc/stb decode straight from the state flop, so reset drops them at once.
  assign wbm.wbm_cyc_o = (state_q == BUS);
  assign wbm.wbm_stb_o = (state_q == BUS);
  assign wbm.wbm_we_o  = we_q;
  assign wbm.wbm_sel_o = sel_q;
  assign wbm.wbm_adr_o = adr_q;
  assign wbm.wbm_dat_o = dat_q;

  assign cmd_ready_o = (state_q == IDLE);
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_dat_o   = rsp_q.dat;
  assign rsp_err_o   = rsp_q.err;
endmodule

// File: tb/tb_wb_host_master.sv
module tb_wb_host_master;
  import wb_pkg::*;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [31:0] cmd_adr = '0, cmd_dat = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
  logic [31:0] rsp_dat;

  int checks = 0;
  int failures = 0;

  wb_host_master_if #(.ADR_W(32), .DAT_W(32)) bus ();

  wb_host_master #(.ADR_W(32), .DAT_W(32), .TIMEOUT(TMO), .TO_W(16)) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_we_i   (cmd_we),
    .cmd_adr_i  (cmd_adr),
    .cmd_dat_i  (cmd_dat),
    .cmd_sel_i  (cmd_sel),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_dat_o  (rsp_dat),
    .rsp_err_o  (rsp_err),
    .wbm        (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a slave that inserts `waits` wait states acks in stb cycle
  // waits+1; the master gives up after TMO stb cycles.
  function automatic wb_rsp_t model_rsp(input logic we, input int waits, input logic [31:0] rd);
    wb_rsp_t r;
    if (waits >= TMO) begin
      r.dat = '0;
      r.err = 1'b1;
    end else begin
      r.dat = we ? 32'h0 : rd;
      r.err = 1'b0;
    end
    return r;
  endfunction

  function automatic int model_stb(input int waits);
    return (waits < TMO) ? waits + 1 : TMO;
  endfunction

  task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                     input logic [3:0] sel, input int waits, input logic [31:0] rd,
                     input int bp);
    int n, lat;
    wb_rsp_t exp_r;
    exp_r = model_rsp(we, waits, rd);
    @(negedge clk);
    chk("cmd_ready_idle", {63'h0, cmd_ready}, 64'h1);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    @(negedge clk);
    // scramble the command inputs: the bus must hold the registered copy
    cmd_valid = 1'b0; cmd_we = ~we; cmd_adr = $urandom; cmd_dat = $urandom; cmd_sel = ~sel;
    n = 0; lat = 1;
    while (!rsp_valid && lat <= TMO + 4) begin
      if (bus.wbm_stb_o) begin
        n++;
        chk("bus_ctl", {60'h0, bus.wbm_cyc_o, bus.wbm_we_o, cmd_ready, 1'b0},
            {60'h0, 1'b1, we, 1'b0, 1'b0});
        chk("bus_sel", {60'h0, bus.wbm_sel_o}, {60'h0, sel});
        chk("bus_adr_dat", {bus.wbm_adr_o, bus.wbm_dat_o}, {adr, dat});
        bus.wbm_ack_i = (n == waits + 1);
        bus.wbm_dat_i = bus.wbm_ack_i ? rd : $urandom;
      end else begin
        bus.wbm_ack_i = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.wbm_ack_i = 1'b0;
    chk("rsp_valid_seen", {63'h0, rsp_valid}, 64'h1);
    chk("latency", 64'(lat), 64'(model_stb(waits) + 1));
    chk("stb_cycles", 64'(n), 64'(model_stb(waits)));
    chk("rsp", {31'h0, rsp_dat, rsp_err}, {31'h0, exp_r});
    chk("bus_idle", {57'h0, bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o}, 64'h0);
    chk("adr_kept", {32'h0, bus.wbm_adr_o}, {32'h0, adr});
    // offer a competing command while the response is back-pressured
    cmd_valid = 1'b1; cmd_adr = $urandom;
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      chk("bp_hold", {28'h0, rsp_valid, cmd_ready, bus.wbm_cyc_o, rsp_dat, rsp_err},
          {28'h0, 1'b1, 1'b0, 1'b0, exp_r});
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done", {62'h0, rsp_valid, cmd_ready}, 64'h1);
  endtask

  initial begin
    bus.wbm_ack_i = 1'b0;
    bus.wbm_dat_i = '0;

    // reset state
    @(negedge clk);
    chk("reset_outs", {56'h0, cmd_ready, rsp_valid, rsp_err, bus.wbm_cyc_o,
                       bus.wbm_stb_o, bus.wbm_we_o, 2'b00}, {56'h0, 8'h80});
    chk("reset_data", {bus.wbm_adr_o | bus.wbm_dat_o, rsp_dat}, 64'h0);
    chk("reset_sel", {60'h0, bus.wbm_sel_o}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // directed cases
    txn(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 0, 32'hFFFF_FFFF, 0);
    txn(1'b0, 32'h3000_0010, 32'h0, 4'hF, 3, 32'h1234_5678, 0);
    txn(1'b0, 32'h3000_0020, 32'h0, 4'h3, 100, 32'hAAAA_5555, 0);
    txn(1'b0, 32'h3000_0024, 32'h0, 4'hF, TMO - 1, 32'hCAFE_F00D, 0);
    txn(1'b1, 32'h3000_0028, 32'h5A5A_A5A5, 4'h1, TMO, 32'h0BAD_0BAD, 0);
    txn(1'b0, 32'h3000_0030, 32'h0, 4'hC, 2, 32'h8765_4321, 5);

    // reset in BUS cycle 2
    @(negedge clk);
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_adr = 32'h3000_0040; cmd_sel = 4'hF;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("rst_bus2_stb", {63'h0, bus.wbm_stb_o}, 64'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_async_drop", {60'h0, bus.wbm_cyc_o, bus.wbm_stb_o, rsp_valid, cmd_ready}, 64'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release", {62'h0, rsp_valid, cmd_ready}, 64'h1);
    bus.wbm_ack_i = 1'b1; bus.wbm_dat_i = 32'hFEED_FACE;
    @(negedge clk);
    bus.wbm_ack_i = 1'b0;
    chk("spurious_ack", {61'h0, bus.wbm_cyc_o, rsp_valid, cmd_ready}, 64'h1);

    // randomized traffic against the reference model
    for (int k = 0; k < 20; k++) begin
      txn(1'($urandom), $urandom, $urandom, 4'($urandom), int'($urandom_range(0, 10)),
          $urandom, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
